// File: rtl/irq_cond_pkg.sv
// Shared constants for the interrupt input conditioner: register map, reset values, defaults.
package irq_cond_pkg;

    localparam int NUM_IRQ_DEF     = 4;
    localparam int FILT_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;

    localparam logic [31:0] ADDR_CTRL   = 32'h0000_0000;
    localparam logic [31:0] ADDR_MODE   = 32'h0000_0004;
    localparam logic [31:0] ADDR_FILT   = 32'h0000_0008;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_000C;

    localparam logic        RST_EN   = 1'b0;
    localparam logic [31:0] RST_EDGE = 32'h0;
    localparam logic [31:0] RST_POL  = 32'h0;
    localparam logic [31:0] RST_FILT = 32'h0;

    function automatic logic addr_is_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr > ADDR_STATUS);
    endfunction

endpackage

// File: rtl/irq_channel_filter.sv
// One interrupt channel: synchronizer, debounce counter, update event and active level.
// upd_o/act_nxt_o describe the value the filter takes at the coming clock edge.
module irq_channel_filter #(
    parameter int FILT_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              pclk_i,
    input  logic              rst_n_i,
    input  logic              raw_i,
    input  logic              pol_i,
    input  logic [FILT_W-1:0] n_i,
    output logic              upd_o,
    output logic              act_o,
    output logic              act_nxt_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   f_q, f_d;
    logic [FILT_W-1:0]      c_q, c_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        f_d   = f_q;
        c_d   = c_q;
        upd_o = 1'b0;
        if (s == f_q) begin
            c_d = '0;
        end else if (c_q == n_i) begin
            f_d   = s;
            c_d   = '0;
            upd_o = 1'b1;
        end else begin
            // A count already past a freshly lowered N keeps running and wraps.
            c_d = c_q + 1'b1;
        end
    end

    assign act_o     = f_q ^ pol_i;
    assign act_nxt_o = f_d ^ pol_i;

    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            f_q    <= 1'b0;
            c_q    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
            f_q    <= f_d;
            c_q    <= c_d;
        end
    end

endmodule

// File: rtl/irq_input_conditioner.sv
// Conditions raw async interrupt sources into triggers for interrupt_controller_v2,
// with APB-programmable debounce, polarity, level/pulse mode and sticky event status.
module irq_input_conditioner
    import irq_cond_pkg::*;
#(
    parameter int NUM_IRQ     = NUM_IRQ_DEF,
    parameter int FILT_W      = FILT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               pclk_i,
    input  logic               rst_n_i,
    input  logic               psel_i,
    input  logic               penable_i,
    input  logic               pwrite_i,
    input  logic [31:0]        paddr_i,
    input  logic [31:0]        pwdata_i,
    output logic [31:0]        prdata_o,
    output logic               pready_o,
    output logic               pslverr_o,
    input  logic [NUM_IRQ-1:0] irq_raw_i,
    output logic [NUM_IRQ-1:0] irq_trigger_o
);

    logic               addr_bad;
    logic               wr_en;
    logic               en_q, en_d;
    logic [NUM_IRQ-1:0] edge_q, edge_d;
    logic [NUM_IRQ-1:0] pol_q, pol_d;
    logic [NUM_IRQ-1:0] evt_q, evt_d;
    logic [NUM_IRQ-1:0] trig_q, trig_d;
    logic [FILT_W-1:0]  n_q, n_d;
    logic [NUM_IRQ-1:0] evt_clr;
    logic [NUM_IRQ-1:0] upd, act, act_nxt;
    logic               unused_pwdata;

    assign addr_bad      = addr_is_bad(paddr_i);
    assign wr_en         = psel_i & penable_i & pwrite_i & ~addr_bad;
    assign pready_o      = 1'b1;
    assign pslverr_o     = psel_i & penable_i & addr_bad;
    assign irq_trigger_o = trig_q;
    assign unused_pwdata = ^pwdata_i;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_chan
        irq_channel_filter #(
            .FILT_W      (FILT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_filt (
            .pclk_i    (pclk_i),
            .rst_n_i   (rst_n_i),
            .raw_i     (irq_raw_i[i]),
            .pol_i     (pol_q[i]),
            .n_i       (n_q),
            .upd_o     (upd[i]),
            .act_o     (act[i]),
            .act_nxt_o (act_nxt[i])
        );
    end

    always_comb begin
        en_d    = en_q;
        edge_d  = edge_q;
        pol_d   = pol_q;
        n_d     = n_q;
        evt_clr = '0;
        if (wr_en) begin
            case (paddr_i)
                ADDR_CTRL:   en_d = pwdata_i[0];
                ADDR_MODE: begin
                    edge_d = pwdata_i[NUM_IRQ-1:0];
                    pol_d  = pwdata_i[4 +: NUM_IRQ];
                end
                ADDR_FILT:   n_d = pwdata_i[FILT_W-1:0];
                ADDR_STATUS: evt_clr = pwdata_i[NUM_IRQ-1:0];
                default: ;
            endcase
        end
        // A new event in the same cycle as its W1C wins.
        evt_d  = (evt_q & ~evt_clr) | (upd & act_nxt);
        trig_d = {NUM_IRQ{en_q}} & ((edge_q & upd & act_nxt) | (~edge_q & act_nxt));
    end

    always_comb begin
        prdata_o = '0;
        if (psel_i && !pwrite_i && !addr_bad) begin
            case (paddr_i)
                ADDR_CTRL:   prdata_o[0] = en_q;
                ADDR_MODE: begin
                    prdata_o[NUM_IRQ-1:0] = edge_q;
                    prdata_o[4 +: NUM_IRQ] = pol_q;
                end
                ADDR_FILT:   prdata_o[FILT_W-1:0] = n_q;
                ADDR_STATUS: begin
                    prdata_o[NUM_IRQ-1:0] = evt_q;
                    prdata_o[8 +: NUM_IRQ] = act;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            en_q   <= RST_EN;
            edge_q <= RST_EDGE[NUM_IRQ-1:0];
            pol_q  <= RST_POL[NUM_IRQ-1:0];
            n_q    <= RST_FILT[FILT_W-1:0];
            evt_q  <= '0;
            trig_q <= '0;
        end else begin
            en_q   <= en_d;
            edge_q <= edge_d;
            pol_q  <= pol_d;
            n_q    <= n_d;
            evt_q  <= evt_d;
            trig_q <= trig_d;
        end
    end

endmodule
